imem_loader: RTL and testbench

Boot-time instruction-memory loader for the single-cycle RISC-V core. It runs between the host byte stream and the core. The block accepts a little-endian byte stream, assembles 32-bit instruction words and writes them to consecutive instruction-memory word addresses from 0. It holds the core in reset until a complete program has loaded. This lets the bench or a board-level UART feed programs without recompiling the memory image.

---
 rtl/imem_loader.sv | 150 +++++++++++++++
 tb/tb_imem_loader.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction-memory loader for the single-cycle RISC-V core.
// The loader takes a little-endian byte stream and builds 32-bit words from
// it. It writes each word to consecutive instruction-memory word addresses,
// starting at 0. The core is held in reset until a complete program has
// loaded. A partial final word or a program longer than IMEM_WORDS aborts
// the load into ERR.
//
// Ports:
//   clk        : system clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   start      : begin a (re)load; honoured only in IDLE, DONE or ERR
//   s_valid    : byte stream valid
//   s_data     : byte stream data
//   s_last     : final byte of the program
//   s_ready    : loader accepts a byte this cycle (high only in LOAD)
//   imem_we    : one-cycle instruction-memory write strobe
//   imem_addr  : word address of the write
//   imem_wdata : assembled instruction word
//   core_rst   : core reset, low only once a program has loaded
//   done       : program loaded successfully
//   error      : load aborted (partial word or overflow)
//   word_count : words written in the current load
// ---------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int IMEM_WORDS = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [7:0]            s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_rst,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   word_count
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      DONE,
      ERR
   } state_t;

   localparam logic [ADDR_WIDTH:0] WORD_LIMIT = (ADDR_WIDTH + 1)'(IMEM_WORDS);
   localparam logic [ADDR_WIDTH:0] COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

   state_t                state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic                  last_q, last_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;

   // Next-state logic. Every register holds its value unless the current
   // state says otherwise. A start in any resting state (IDLE, DONE, ERR)
   // clears the counters and the byte index, so a reload always begins at
   // word address 0. In LOAD, s_ready is high by definition, so s_valid
   // alone marks an accepted byte. The byte index wraps 3 -> 0 on its own
   // once a word is complete.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      count_d = count_q;
      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               count_d = '0;
               addr_d  = '0;
               idx_d   = '0;
               last_d  = 1'b0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (s_valid) begin
               wdata_d[8*idx_q +: 8] = s_data;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  last_d  = s_last;
                  state_d = WRITE;
               end else if (s_last) begin
                  // The program ended mid-word. The partial word is dropped.
                  state_d = ERR;
               end
            end
         end
         WRITE: begin
            addr_d  = addr_q + ADDR_ONE;
            count_d = count_q + COUNT_ONE;
            idx_d   = '0;
            // A final word that exactly fills memory is still a success.
            if (last_q) begin
               state_d = DONE;
            end else if (count_q + COUNT_ONE == WORD_LIMIT) begin
               state_d = ERR;
            end else begin
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. The synchronous reset abandons any
   // partial word or pending write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         last_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         count_q <= count_d;
      end
   end

   // Outputs are either registers or decoded straight from the state
   // register. No stream input reaches an output combinationally.
   assign s_ready    = (state_q == LOAD);
   assign imem_we    = (state_q == WRITE);
   assign done       = (state_q == DONE);
   assign error      = (state_q == ERR);
   assign core_rst   = (state_q != DONE);
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Two instances share one set of
// stimulus inputs. The first uses the default 256-word memory. The second
// is limited to 4 words, to reach the overflow boundary. A word-level
// reference model predicts the writes and the final status of each program.
// The bench compares these predictions with the writes it observes.
// ---------------------------------------------------------------------------
module tb_imem_loader;

   typedef struct {
      logic [7:0] d;
      bit         last;
   } byte_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;

   logic        a_ready, a_we, a_core_rst, a_done, a_error;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata;
   logic [8:0]  a_count;

   logic        b_ready, b_we, b_core_rst, b_done, b_error;
   logic [7:0]  b_addr;
   logic [31:0] b_wdata;
   logic [8:0]  b_count;

   bit          sel;
   int          checks;
   int          errors;
   byte_t       bq[$];
   logic [31:0] expWords[$];
   logic [39:0] obsA[$];
   logic [39:0] obsB[$];

   logic        readySel, weSel, coreRstSel, doneSel, errSel;
   logic [7:0]  addrSel;
   logic [8:0]  countSel;

   imem_loader dutA (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid),
      .s_data(s_data), .s_last(s_last), .s_ready(a_ready),
      .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
      .core_rst(a_core_rst), .done(a_done), .error(a_error),
      .word_count(a_count)
   );

   imem_loader #(.ADDR_WIDTH(8), .IMEM_WORDS(4)) dutB (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid),
      .s_data(s_data), .s_last(s_last), .s_ready(b_ready),
      .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
      .core_rst(b_core_rst), .done(b_done), .error(b_error),
      .word_count(b_count)
   );

   // sel picks which instance the driver and the checks look at.
   assign readySel   = sel ? b_ready    : a_ready;
   assign weSel      = sel ? b_we       : a_we;
   assign addrSel    = sel ? b_addr     : a_addr;
   assign coreRstSel = sel ? b_core_rst : a_core_rst;
   assign doneSel    = sel ? b_done     : a_done;
   assign errSel     = sel ? b_error    : a_error;
   assign countSel   = sel ? b_count    : a_count;

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write monitor. It samples on the falling edge, away from the active
   // edge, and records every write as {addr, data}.
   always @(negedge clk) begin
      if (a_we === 1'b1) obsA.push_back({a_addr, a_wdata});
      if (b_we === 1'b1) obsB.push_back({b_addr, b_wdata});
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Word-level reference. Every four bytes form one little-endian word.
   // A last flag mid-word aborts the load. A last flag on a word boundary
   // finishes it. Filling the memory without a last flag aborts the load
   // and consumes nothing more.
   task automatic modelRun(input int limit, output int nUsed,
                           output bit expDone, output bit expErr);
      logic [31:0] w;
      int k;
      expWords.delete();
      w = '0;
      k = 0;
      nUsed = 0;
      expDone = 1'b0;
      expErr = 1'b0;
      for (int i = 0; i < bq.size(); i++) begin
         nUsed = i + 1;
         w = {bq[i].d, w[31:8]};
         k++;
         if (k == 4) begin
            expWords.push_back(w);
            k = 0;
            if (bq[i].last) begin
               expDone = 1'b1;
               break;
            end
            if (expWords.size() == limit) begin
               expErr = 1'b1;
               break;
            end
         end else if (bq[i].last) begin
            expErr = 1'b1;
            break;
         end
      end
   endtask

   task automatic addByte(input logic [7:0] d, input bit last);
      byte_t b;
      b.d = d;
      b.last = last;
      bq.push_back(b);
   endtask

   task automatic startPulse();
      s_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("start_to_ready", readySel, 1);
   endtask

   // Presents one byte after an optional random gap. Returns ok = 1 once a
   // rising edge sees s_valid && s_ready, or ok = 0 after budget cycles.
   task automatic applyStimulus(input logic [7:0] d, input bit last,
                                input int gapMax, input int budget,
                                output bit ok);
      int gap;
      gap = $urandom_range(gapMax, 0);
      repeat (gap) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_data = d;
      s_last = last;
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (readySel === 1'b1) begin
            ok = 1'b1;
            @(posedge clk);
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
      s_last = 1'b0;
   endtask

   // Runs the program held in bq on the selected instance. Checks each
   // accept and each write strobe, then the whole write trace and the
   // final status against the model.
   task automatic runProgram(input int gapMax);
      int nUsed;
      bit eDone, eErr, ok;
      logic [39:0] o;
      modelRun(sel ? 4 : 256, nUsed, eDone, eErr);
      obsA.delete();
      obsB.delete();
      startPulse();
      for (int i = 0; i < nUsed; i++) begin
         applyStimulus(bq[i].d, bq[i].last, gapMax, 200, ok);
         checkOutput("byte_accept", ok, 1);
         if (!ok) break;
         if (i % 4 == 3) begin
            checkOutput("we_after_word", weSel, 1);
            checkOutput("addr_at_write", addrSel, i / 4);
         end
      end
      repeat (2) @(negedge clk);
      checkOutput("write_count", sel ? obsB.size() : obsA.size(),
                  expWords.size());
      for (int i = 0; i < expWords.size(); i++) begin
         if (i < (sel ? obsB.size() : obsA.size())) begin
            o = sel ? obsB[i] : obsA[i];
            checkOutput("write_addr", o[39:32], i);
            checkOutput("write_data", o[31:0], expWords[i]);
         end
      end
      checkOutput("final_done", doneSel, eDone);
      checkOutput("final_error", errSel, eErr);
      checkOutput("final_core_rst", coreRstSel, !eDone);
      checkOutput("final_count", countSel, expWords.size());
      checkOutput("final_ready", readySel, 0);
   endtask

   task automatic pulseReset();
      s_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit ok;
      int n;
      checks = 0;
      errors = 0;
      sel = 1'b0;
      rst = 1'b1;
      start = 1'b0;
      s_valid = 1'b0;
      s_data = '0;
      s_last = 1'b0;

      // Reset held for two cycles.
      repeat (2) @(negedge clk);
      checkOutput("rst_ready", a_ready, 0);
      checkOutput("rst_we", a_we, 0);
      checkOutput("rst_addr", a_addr, 0);
      checkOutput("rst_wdata", a_wdata, 0);
      checkOutput("rst_core_rst", a_core_rst, 1);
      checkOutput("rst_done", a_done, 0);
      checkOutput("rst_error", a_error, 0);
      checkOutput("rst_count", a_count, 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed three-word program with s_valid held high.
      bq.delete();
      addByte(8'h13, 0); addByte(8'h00, 0); addByte(8'h00, 0); addByte(8'h00, 0);
      addByte(8'h93, 0); addByte(8'h00, 0); addByte(8'h10, 0); addByte(8'h00, 0);
      addByte(8'h33, 0); addByte(8'h81, 0); addByte(8'h20, 0); addByte(8'h00, 1);
      runProgram(0);
      if (obsA.size() >= 3) begin
         checkOutput("w0_const", obsA[0][31:0], 32'h00000013);
         checkOutput("w1_const", obsA[1][31:0], 32'h00100093);
         checkOutput("w2_const", obsA[2][31:0], 32'h00208133);
      end
      checkOutput("three_done", a_done, 1);
      checkOutput("three_count", a_count, 3);

      // The same program again, with random gaps in s_valid.
      repeat (2) runProgram(3);

      // Random programs of 1..6 words, started from DONE.
      repeat (4) begin
         bq.delete();
         n = $urandom_range(6, 1);
         for (int i = 0; i < 4 * n; i++)
            addByte(8'($urandom), i == 4 * n - 1);
         runProgram(2);
      end

      // Partial word: the last flag on the 6th byte.
      bq.delete();
      for (int i = 0; i < 6; i++) addByte(8'($urandom), i == 5);
      runProgram(2);
      checkOutput("partial_writes", obsA.size(), 1);
      checkOutput("partial_error", a_error, 1);
      checkOutput("partial_count", a_count, 1);

      // Overflow on the 4-word instance: five words, no last flag.
      pulseReset();
      sel = 1'b1;
      bq.delete();
      for (int i = 0; i < 20; i++) addByte(8'($urandom), 0);
      runProgram(1);
      checkOutput("ovf_writes", obsB.size(), 4);
      checkOutput("ovf_error", b_error, 1);
      checkOutput("ovf_count", b_count, 4);
      applyStimulus(8'hA5, 0, 0, 20, ok);
      checkOutput("ovf_reject", ok, 0);

      // Random programs around the 4-word boundary on the small instance.
      repeat (3) begin
         bq.delete();
         n = $urandom_range(6, 3);
         for (int i = 0; i < 4 * n; i++)
            addByte(8'($urandom), i == 4 * n - 1);
         runProgram(1);
      end

      // Reset mid-word, then a fresh one-word program.
      pulseReset();
      sel = 1'b0;
      startPulse();
      applyStimulus(8'hDE, 0, 0, 20, ok);
      applyStimulus(8'hAD, 0, 0, 20, ok);
      pulseReset();
      checkOutput("midrst_ready", a_ready, 0);
      checkOutput("midrst_core_rst", a_core_rst, 1);
      checkOutput("midrst_wdata", a_wdata, 0);
      bq.delete();
      addByte(8'h11, 0); addByte(8'h22, 0); addByte(8'h33, 0); addByte(8'h44, 1);
      runProgram(0);
      if (obsA.size() >= 1)
         checkOutput("reload_word", obsA[0], {8'h00, 32'h44332211});
      checkOutput("reload_done", a_done, 1);

      // Reload from DONE.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("restart_core_rst", a_core_rst, 1);
      checkOutput("restart_count", a_count, 0);
      checkOutput("restart_done", a_done, 0);
      checkOutput("restart_ready", a_ready, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
